load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port: Clock  input  1  single clock; all state updates on posedge Clock.
REQ-002 SHALL have port: Reset  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: req  input  1  request strobe; sampled only in IDLE.
REQ-004 SHALL have port: we  input  1  1 = store, 0 = load.
REQ-005 SHALL have port: size  input  2  access size: byte, half or word (encodings per REQ-032).
REQ-006 SHALL have port: sign_ext  input  1  load sign-extension enable; ignored for word accesses and stores.
REQ-007 SHALL have port: addr  input  32  byte address; little-endian.
REQ-008 SHALL have port: wdata  input  32  store data; right-justified.
REQ-009 SHALL have port: rdata  output  32  load result; held until next accepted request.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: err  output  1  misalignment flag; valid while done=1.
REQ-013 SHALL have port: mem_addr  output  32  word-aligned address: {addr[31:2],2'b00}.
REQ-014 SHALL have port: mem_datain  output  32  write data to the data memory.
REQ-015 SHALL have port: mem_dataout  input  32  combinational read data from the data memory.
REQ-016 SHALL have ports: mem_write, mem_read  output  1 each  memory strobes; the memory commits its write on posedge Clock.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, WRITE, DONE.
REQ-018 SHALL, on req=1 in IDLE, capture we/size/sign_ext/addr/wdata and enter ACCESS (or DONE on a misaligned request; see REQ-029).
REQ-019 SHALL ignore req while busy=1; there is no queueing.
REQ-020 SHALL, in ACCESS for a load, assert mem_read, latch the extracted lane into rdata, and enter DONE.
REQ-021 SHALL, in ACCESS for a word store, assert mem_write with mem_datain=wdata, and enter DONE.
REQ-022 SHALL, in ACCESS for a byte or half store, assert mem_read, latch mem_dataout, and enter WRITE.
REQ-023 SHALL, in WRITE, assert mem_write with mem_datain = latched word with only the target lane(s) replaced by wdata[7:0] or wdata[15:0], and enter DONE.
REQ-024 SHALL, in DONE, assert done=1 for exactly one cycle and then return to IDLE.
REQ-025 SHALL achieve these latencies, with the request accepted at cycle 0:
- load and word store: done at cycle 2;
- sub-word store: done at cycle 3.
REQ-026 SHALL select the byte lane by addr[1:0] and the half lane by addr[1].
REQ-027 SHALL fill the upper bits of a load with the lane MSB when sign_ext=1, and with zero otherwise.
REQ-028 SHALL keep mem_read and mem_write at 0 outside the states listed above; mem_write SHALL never be high in the same cycle as mem_read.

Reset
REQ-029 SHALL handle misaligned requests (half with addr[0]=1; word with addr[1:0]!=0) as follows:
- go IDLE to DONE directly;
- perform no memory access;
- drive err=1 and rdata=0.
REQ-030 SHALL, on Reset=1, enter IDLE on the next edge and drive rdata=0, busy=0, done=0, err=0.
REQ-031 SHALL gate mem_write and mem_read with !Reset combinationally, so that a reset asserted mid-operation (including in WRITE) commits no memory write; the captured request is discarded.

Configuration
REQ-032 SHALL define the size encodings as: byte=2'b00, half=2'b01, word=2'b10; 2'b11 SHALL be treated as word.
REQ-033 SHALL, with macro LSU_MISALIGN_TRAP_EN defined, perform the misalignment trap of REQ-029.
REQ-034 SHALL, without LSU_MISALIGN_TRAP_EN:
- tie err to 0;
- force misaligned addresses to natural alignment (clear addr[0] for half, addr[1:0] for word) and complete normally.

Structure
REQ-035 SHALL place the size encodings, FSM state encodings and lane-mask constants in shared package lsu_pkg.
REQ-036 SHALL implement lane extract/merge as combinational sub-module lsu_lane_align, instantiated once; the FSM, capture registers and rdata register reside in load_store_unit.

Verification
REQ-037 SHALL cover these directed scenarios (Word address = addr[6:2]):
- Load word: memory word 1 = 3; load word, addr=0x4 -> rdata=0x00000003, done at cycle 2, err=0.
- Signed byte load: memory word 2 = 0x000080FF; load byte, addr=0x9, sign_ext=1 -> rdata=0xFFFFFF80; same with sign_ext=0 -> rdata=0x00000080.
- Byte store: memory word 0 = 0x00000002; store byte, addr=0x2, wdata=0x123456AB -> word 0 becomes 0x00AB0002, done at cycle 3, exactly one mem_write cycle.
- Misaligned half (LSU_MISALIGN_TRAP_EN defined): load half, addr=0x3 -> done at cycle 1, err=1, rdata=0, no mem_read or mem_write.
- Reset in WRITE: half store to addr=0x4, Reset=1 during WRITE -> memory word 1 unchanged, busy=0 on the next cycle, no done pulse.
- Request while busy: second req during ACCESS of a load -> second request ignored, single done pulse, rdata from the first request only.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM
// state encodings, lane masks and small decode helpers.
package lsu_pkg;

   // Access size encodings; 2'b11 is handled exactly like a word access.
   typedef enum logic [1:0] {
      SIZE_BYTE     = 2'b00,
      SIZE_HALF     = 2'b01,
      SIZE_WORD     = 2'b10,
      SIZE_WORD_ALT = 2'b11
   } lsu_size_e;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      WRITE  = 2'b10,
      DONE   = 2'b11
   } lsu_state_e;

   // Right-justified lane masks, shifted into position by the lane aligner.
   localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
   localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
   localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

   // Word accesses are both 2'b10 and 2'b11, so bit 1 alone identifies them.
   function automatic logic size_is_word(input logic [1:0] size);
      return size[1];
   endfunction

   // True when the address is not naturally aligned for the access size.
   function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SIZE_BYTE: mis = 1'b0;
         SIZE_HALF: mis = addr_lo[0];
         default:   mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane aligner: extracts a byte/half/word load result from a
// memory word (with optional sign extension) and merges store data into a
// previously read word for sub-word stores. Little-endian lane numbering.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        sign_ext,
   input  logic [31:0] rd_word,
   input  logic [31:0] base_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [4:0]  shift_s;
   logic [31:0] mask_s;
   logic [31:0] shifted_s;

   // Decode lane position (bit shift) and lane width (mask) from size/address.
   always_comb begin
      shift_s = 5'd0;
      mask_s  = LANE_MASK_WORD;
      case (size)
         SIZE_BYTE: begin
            shift_s = {lane, 3'b000};
            mask_s  = LANE_MASK_BYTE;
         end
         SIZE_HALF: begin
            shift_s = {lane[1], 4'b0000};
            mask_s  = LANE_MASK_HALF;
         end
         default: begin
            shift_s = 5'd0;
            mask_s  = LANE_MASK_WORD;
         end
      endcase
   end

   assign shifted_s = rd_word >> shift_s;

   // Right-justify the selected lane and fill the upper bits with zero or its MSB.
   always_comb begin
      load_data = shifted_s;
      case (size)
         SIZE_BYTE: load_data = {{24{sign_ext & shifted_s[7]}}, shifted_s[7:0]};
         SIZE_HALF: load_data = {{16{sign_ext & shifted_s[15]}}, shifted_s[15:0]};
         default:   load_data = shifted_s;
      endcase
   end

   // Replace only the target lane(s) of the read word with the store data.
   always_comb begin
      merge_data = (base_word & ~(mask_s << shift_s)) | ((wdata & mask_s) << shift_s);
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding byte/half/word accesses to a data memory
// with combinational read and clocked write. Sub-word stores are performed as
// read-modify-write.
// Optional feature: define LSU_MISALIGN_TRAP_EN to report misaligned requests
// through err without touching memory; otherwise misaligned addresses are
// silently forced to natural alignment.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_datain,
   input  logic [31:0] mem_dataout,
   output logic        mem_write,
   output logic        mem_read
);

   lsu_state_e  state_r, state_s;
   logic        we_r, sign_ext_r;
   logic [1:0]  size_r;
   logic [31:0] addr_r, wdata_r, word_r, rdata_r;
   logic [31:0] addr_cap_s, load_s, merge_s;
   logic        trap_s, accept_s;
   logic        mem_read_s, mem_write_s;
   logic [31:0] mem_datain_s;

   assign accept_s = (state_r == IDLE) && req;

`ifdef LSU_MISALIGN_TRAP_EN
   logic err_r;

   // Misaligned requests bypass memory; the address is kept as given.
   always_comb begin
      trap_s     = size_misaligned(size, addr[1:0]);
      addr_cap_s = addr;
   end

   // Error flag is decided at acceptance and held through the DONE pulse.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         err_r <= 1'b0;
      end else if (accept_s) begin
         err_r <= trap_s;
      end else begin
         err_r <= err_r;
      end
   end

   assign err = err_r;
`else
   // No trap: clear the low address bits that a naturally aligned access ignores.
   always_comb begin
      trap_s = 1'b0;
      if (size_is_word(size)) begin
         addr_cap_s = {addr[31:2], 2'b00};
      end else if (size == SIZE_HALF) begin
         addr_cap_s = {addr[31:1], 1'b0};
      end else begin
         addr_cap_s = addr;
      end
   end

   assign err = 1'b0;
`endif

   lsu_lane_align u_lane_align (
      .size       (size_r),
      .lane       (addr_r[1:0]),
      .sign_ext   (sign_ext_r),
      .rd_word    (mem_dataout),
      .base_word  (word_r),
      .wdata      (wdata_r),
      .load_data  (load_s),
      .merge_data (merge_s)
   );

   // State register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and memory strobe decode.
   always_comb begin
      state_s      = state_r;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      mem_datain_s = 32'h0000_0000;
      case (state_r)
         IDLE: begin
            if (req) begin
               state_s = trap_s ? DONE : ACCESS;
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            if (!we_r) begin
               mem_read_s = 1'b1;
               state_s    = DONE;
            end else if (size_is_word(size_r)) begin
               mem_write_s  = 1'b1;
               mem_datain_s = wdata_r;
               state_s      = DONE;
            end else begin
               mem_read_s = 1'b1;
               state_s    = WRITE;
            end
         end
         WRITE: begin
            mem_write_s  = 1'b1;
            mem_datain_s = merge_s;
            state_s      = DONE;
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Request capture; a request is taken only while idle.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         we_r       <= 1'b0;
         size_r     <= 2'b00;
         sign_ext_r <= 1'b0;
         addr_r     <= 32'h0000_0000;
         wdata_r    <= 32'h0000_0000;
      end else if (accept_s) begin
         we_r       <= we;
         size_r     <= size;
         sign_ext_r <= sign_ext;
         addr_r     <= addr_cap_s;
         wdata_r    <= wdata;
      end else begin
         we_r       <= we_r;
         size_r     <= size_r;
         sign_ext_r <= sign_ext_r;
         addr_r     <= addr_r;
         wdata_r    <= wdata_r;
      end
   end

   // Read-modify-write holding word, loaded during ACCESS.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         word_r <= 32'h0000_0000;
      end else if (state_r == ACCESS) begin
         word_r <= mem_dataout;
      end else begin
         word_r <= word_r;
      end
   end

   // Load result register: updated by loads, zeroed by a trapped request.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         rdata_r <= 32'h0000_0000;
      end else if (accept_s && trap_s) begin
         rdata_r <= 32'h0000_0000;
      end else if ((state_r == ACCESS) && !we_r) begin
         rdata_r <= load_s;
      end else begin
         rdata_r <= rdata_r;
      end
   end

   assign rdata      = rdata_r;
   assign busy       = (state_r != IDLE);
   assign done       = (state_r == DONE);
   assign mem_addr   = {addr_r[31:2], 2'b00};
   assign mem_datain = mem_datain_s;
   // Reset blocks any strobe in the same cycle so an interrupted store never commits.
   assign mem_read   = mem_read_s & ~Reset;
   assign mem_write  = mem_write_s & ~Reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a 32-word memory model.
module tb_load_store_unit;

   localparam logic [1:0] SZ_B  = 2'b00;
   localparam logic [1:0] SZ_H  = 2'b01;
   localparam logic [1:0] SZ_W  = 2'b10;
   localparam logic [1:0] SZ_W3 = 2'b11;
   localparam int NVEC = 18;

   logic        Clock, Reset, req, we, sign_ext;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata, mem_addr, mem_datain, mem_dataout;
   logic        busy, done, err, mem_write, mem_read;

   logic [31:0] mem [0:31];
   logic        pre_en;
   logic [4:0]  pre_idx;
   logic [31:0] pre_val;
   int rd_cnt, wr_cnt, done_cnt, overlap_cnt;
   int tests, fails;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  pidx;
      logic [31:0] pval;
      logic        chk_rd;
      logic [31:0] exp_rdata;
      logic [31:0] exp_mem;
      int          exp_lat;
      logic        exp_err;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   vec_t vecs [NVEC];

   load_store_unit dut (
      .Clock(Clock), .Reset(Reset), .req(req), .we(we), .size(size),
      .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
      .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
      .mem_datain(mem_datain), .mem_dataout(mem_dataout),
      .mem_write(mem_write), .mem_read(mem_read)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Memory model: preload port for the bench, clocked write from the DUT.
   always @(posedge Clock) begin
      if (pre_en) mem[pre_idx] <= pre_val;
      else if (mem_write) mem[mem_addr[6:2]] <= mem_datain;
   end
   assign mem_dataout = mem[mem_addr[6:2]];

   // Strobe and pulse counters sampled mid-cycle.
   always @(negedge Clock) begin
      if (mem_read === 1'b1) rd_cnt <= rd_cnt + 1;
      if (mem_write === 1'b1) wr_cnt <= wr_cnt + 1;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (mem_read === 1'b1 && mem_write === 1'b1) overlap_cnt <= overlap_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [4:0] idx, input logic [31:0] val);
      @(negedge Clock);
      pre_en = 1'b1; pre_idx = idx; pre_val = val;
      @(posedge Clock);
      #1 pre_en = 1'b0;
   endtask

   task automatic run_vec(input int n);
      int lat, rd0, wr0;
      bit seen;
      string tag;
      tag = $sformatf("v%0d", n);
      preload(vecs[n].pidx, vecs[n].pval);
      @(negedge Clock);
      we = vecs[n].we; size = vecs[n].size; sign_ext = vecs[n].sext;
      addr = vecs[n].addr; wdata = vecs[n].wdata; req = 1'b1;
      rd0 = rd_cnt; wr0 = wr_cnt;
      @(posedge Clock);
      #1 req = 1'b0;
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      seen = 1'b0;
      lat = 1;
      while (!seen && lat <= 8) begin
         if (done === 1'b1) seen = 1'b1;
         else begin
            @(posedge Clock);
            #1 lat++;
         end
      end
      if (!seen) begin
         tests++; fails++;
         $display("FAIL %s timeout: no done within 8 cycles", tag);
      end else begin
         check({tag, " latency"}, lat, vecs[n].exp_lat);
         check({tag, " err"}, {31'd0, err}, {31'd0, vecs[n].exp_err});
         if (vecs[n].chk_rd) check({tag, " rdata"}, rdata, vecs[n].exp_rdata);
         @(posedge Clock);
         #1;
         check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
         check({tag, " idle"}, {31'd0, busy}, 32'd0);
         check({tag, " mem word"}, mem[vecs[n].pidx], vecs[n].exp_mem);
         check({tag, " reads"}, rd_cnt - rd0, vecs[n].exp_rd);
         check({tag, " writes"}, wr_cnt - wr0, vecs[n].exp_wr);
      end
   endtask

   initial begin
      int d0, w0, r0;
      tests = 0; fails = 0;
      rd_cnt = 0; wr_cnt = 0; done_cnt = 0; overlap_cnt = 0;
      pre_en = 1'b0; pre_idx = 5'd0; pre_val = 32'd0;
      req = 1'b0; we = 1'b0; size = SZ_W; sign_ext = 1'b0; addr = 32'd0; wdata = 32'd0;

      //            we    size   sx    addr   wdata         pidx  pval          chk   exp_rdata     exp_mem      lat err rd wr
      vecs[0]  = '{1'b0, SZ_W,  1'b0, 32'h4, 32'h0,        5'd1, 32'h00000003, 1'b1, 32'h00000003, 32'h00000003, 2, 1'b0, 1, 0};
      vecs[1]  = '{1'b0, SZ_B,  1'b1, 32'h9, 32'h0,        5'd2, 32'h000080FF, 1'b1, 32'hFFFFFF80, 32'h000080FF, 2, 1'b0, 1, 0};
      vecs[2]  = '{1'b0, SZ_B,  1'b0, 32'h9, 32'h0,        5'd2, 32'h000080FF, 1'b1, 32'h00000080, 32'h000080FF, 2, 1'b0, 1, 0};
      vecs[3]  = '{1'b0, SZ_B,  1'b1, 32'h8, 32'h0,        5'd2, 32'h000080FF, 1'b1, 32'hFFFFFFFF, 32'h000080FF, 2, 1'b0, 1, 0};
      vecs[4]  = '{1'b0, SZ_H,  1'b1, 32'hE, 32'h0,        5'd3, 32'h80011234, 1'b1, 32'hFFFF8001, 32'h80011234, 2, 1'b0, 1, 0};
      vecs[5]  = '{1'b0, SZ_H,  1'b0, 32'hE, 32'h0,        5'd3, 32'h80011234, 1'b1, 32'h00008001, 32'h80011234, 2, 1'b0, 1, 0};
      vecs[6]  = '{1'b0, SZ_H,  1'b1, 32'hC, 32'h0,        5'd3, 32'h80011234, 1'b1, 32'h00001234, 32'h80011234, 2, 1'b0, 1, 0};
      vecs[7]  = '{1'b0, SZ_B,  1'b0, 32'hF, 32'h0,        5'd3, 32'h80011234, 1'b1, 32'h00000080, 32'h80011234, 2, 1'b0, 1, 0};
      vecs[8]  = '{1'b0, SZ_W3, 1'b1, 32'h10, 32'h0,       5'd4, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 2, 1'b0, 1, 0};
      vecs[9]  = '{1'b1, SZ_B,  1'b0, 32'h2, 32'h123456AB, 5'd0, 32'h00000002, 1'b0, 32'h0,        32'h00AB0002, 3, 1'b0, 1, 1};
      vecs[10] = '{1'b1, SZ_H,  1'b0, 32'h6, 32'hAAAA5678, 5'd1, 32'h11223344, 1'b0, 32'h0,        32'h56783344, 3, 1'b0, 1, 1};
      vecs[11] = '{1'b1, SZ_H,  1'b1, 32'h4, 32'hAAAA5678, 5'd1, 32'h11223344, 1'b0, 32'h0,        32'h11225678, 3, 1'b0, 1, 1};
      vecs[12] = '{1'b1, SZ_W,  1'b0, 32'h14, 32'hCAFEF00D, 5'd5, 32'h00000000, 1'b0, 32'h0,       32'hCAFEF00D, 2, 1'b0, 0, 1};
      vecs[13] = '{1'b1, SZ_B,  1'b0, 32'h17, 32'h000000EE, 5'd5, 32'h01020304, 1'b0, 32'h0,       32'hEE020304, 3, 1'b0, 1, 1};
      vecs[14] = '{1'b1, SZ_B,  1'b0, 32'h18, 32'h000000FF, 5'd6, 32'hAABBCCDD, 1'b0, 32'h0,       32'hAABBCCFF, 3, 1'b0, 1, 1};
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[15] = '{1'b0, SZ_H,  1'b0, 32'h3, 32'h0,        5'd0, 32'h80017766, 1'b1, 32'h00000000, 32'h80017766, 1, 1'b1, 0, 0};
      vecs[16] = '{1'b0, SZ_W,  1'b0, 32'h26, 32'h0,       5'd9, 32'h01234567, 1'b1, 32'h00000000, 32'h01234567, 1, 1'b1, 0, 0};
      vecs[17] = '{1'b1, SZ_W3, 1'b0, 32'h21, 32'h13579BDF, 5'd8, 32'h00000000, 1'b0, 32'h0,       32'h00000000, 1, 1'b1, 0, 0};
`else
      vecs[15] = '{1'b0, SZ_H,  1'b0, 32'h3, 32'h0,        5'd0, 32'h80017766, 1'b1, 32'h00008001, 32'h80017766, 2, 1'b0, 1, 0};
      vecs[16] = '{1'b0, SZ_W,  1'b0, 32'h26, 32'h0,       5'd9, 32'h01234567, 1'b1, 32'h01234567, 32'h01234567, 2, 1'b0, 1, 0};
      vecs[17] = '{1'b1, SZ_W3, 1'b0, 32'h21, 32'h13579BDF, 5'd8, 32'h00000000, 1'b0, 32'h0,       32'h13579BDF, 2, 1'b0, 0, 1};
`endif

      // Reset state
      Reset = 1'b1;
      repeat (3) @(posedge Clock);
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset err", {31'd0, err}, 32'd0);
      check("reset rdata", rdata, 32'd0);
      check("reset strobes", {30'd0, mem_read, mem_write}, 32'd0);
      Reset = 1'b0;

      for (int i = 0; i < NVEC; i++) run_vec(i);

      // Reset asserted in WRITE of a half store: no write, back to idle, no done
      preload(5'd1, 32'h11223344);
      @(negedge Clock);
      we = 1'b1; size = SZ_H; sign_ext = 1'b0; addr = 32'h4; wdata = 32'h0000BEEF; req = 1'b1;
      @(posedge Clock);
      #1 req = 1'b0;
      @(posedge Clock);
      #1;
      check("rstw in write busy", {31'd0, busy}, 32'd1);
      d0 = done_cnt; w0 = wr_cnt;
      Reset = 1'b1;
      @(posedge Clock);
      #1 Reset = 1'b0;
      check("rstw busy", {31'd0, busy}, 32'd0);
      check("rstw done", {31'd0, done}, 32'd0);
      check("rstw rdata", rdata, 32'd0);
      repeat (4) @(posedge Clock);
      #1;
      check("rstw mem word", mem[1], 32'h11223344);
      check("rstw no done", done_cnt - d0, 32'd0);
      check("rstw no write", wr_cnt - w0, 32'd0);

      // Second request during ACCESS of a load is ignored
      @(negedge Clock);
      we = 1'b0; size = SZ_W; sign_ext = 1'b0; addr = 32'h4; wdata = 32'h0; req = 1'b1;
      d0 = done_cnt; r0 = rd_cnt;
      @(posedge Clock);
      #1 addr = 32'h10;
      @(posedge Clock);
      #1 req = 1'b0;
      repeat (4) @(posedge Clock);
      #1;
      check("busyreq done pulses", done_cnt - d0, 32'd1);
      check("busyreq reads", rd_cnt - r0, 32'd1);
      check("busyreq rdata", rdata, 32'h11223344);
      check("busyreq idle", {31'd0, busy}, 32'd0);

      check("read/write overlap", overlap_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
